// File: rtl/button_step_ctrl.sv
// Push-button front end for the LED counter: synchronise, debounce, step once per
// press, auto-repeat on a long hold, and gate steps against clear and saturation.
module button_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter bit WRAP            = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic       dir_up,
  input  logic       clr_req,
  input  logic [7:0] cnt_val,
  output logic       cnt_inc,
  output logic       cnt_dec,
  output logic       cnt_clr,
  output logic       limit_hit,
  output logic       busy
);

  localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_T  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int TW     = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] DB_LAST   = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    RELEASE_DB
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          sync1;
  logic          b_s;
  logic          fire;
  logic          suppress;

  // A step fires on the edge where the debounce/hold/repeat interval completes
  // with the button still down.
  assign fire = b_s && (((state == PRESS_DB) && (timer == DB_LAST)) ||
                        ((state == HELD)     && (timer == HOLD_LAST)) ||
                        ((state == REPEAT)   && (timer == REP_LAST)));

  assign suppress = !WRAP && (dir_up ? (cnt_val == 8'hFF) : (cnt_val == 8'h00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      b_s   <= 1'b0;
    end else begin
      sync1 <= button;
      b_s   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      cnt_inc   <= 1'b0;
      cnt_dec   <= 1'b0;
      cnt_clr   <= 1'b0;
      limit_hit <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt_inc   <= 1'b0;
      cnt_dec   <= 1'b0;
      limit_hit <= 1'b0;
      cnt_clr   <= clr_req;

      // A clear on the same edge swallows the step; the FSM still advances.
      if (fire && !clr_req) begin
        if (suppress) begin
          limit_hit <= 1'b1;
        end else if (dir_up) begin
          cnt_inc <= 1'b1;
        end else begin
          cnt_dec <= 1'b1;
        end
      end

      timer <= timer + TW'(1);

      case (state)
        IDLE: begin
          if (b_s) begin
            state <= PRESS_DB;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        PRESS_DB: begin
          if (!b_s) begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
          end else if (timer == DB_LAST) begin
            state <= HELD;
            timer <= '0;
          end
        end
        HELD: begin
          if (!b_s) begin
            state <= RELEASE_DB;
            timer <= '0;
          end else if (timer == HOLD_LAST) begin
            state <= REPEAT;
            timer <= '0;
          end
        end
        REPEAT: begin
          if (!b_s) begin
            state <= RELEASE_DB;
            timer <= '0;
          end else if (timer == REP_LAST) begin
            timer <= '0;
          end
        end
        RELEASE_DB: begin
          // A bounce back high returns to HELD without issuing a step.
          if (b_s) begin
            state <= HELD;
            timer <= '0;
          end else if (timer == DB_LAST) begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_step_ctrl.sv
// Bench for button_step_ctrl: directed scenarios with literal pulse-edge checks plus
// randomized button traffic, both checked every cycle against a deadline-based model.
module tb_button_step_ctrl;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic       dir_up = 1'b0;
  logic       clr_req = 1'b0;
  logic [7:0] cnt_val = 8'h00;

  logic o0_inc, o0_dec, o0_clr, o0_lim, o0_busy;
  logic o1_inc, o1_dec, o1_clr, o1_lim, o1_busy;

  button_step_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .WRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .button(button), .dir_up(dir_up), .clr_req(clr_req),
    .cnt_val(cnt_val), .cnt_inc(o0_inc), .cnt_dec(o0_dec), .cnt_clr(o0_clr),
    .limit_hit(o0_lim), .busy(o0_busy)
  );

  button_step_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .WRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .button(button), .dir_up(dir_up), .clr_req(clr_req),
    .cnt_val(cnt_val), .cnt_inc(o1_inc), .cnt_dec(o1_dec), .cnt_clr(o1_clr),
    .limit_hit(o1_lim), .busy(o1_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Posedge counter used to express pulse times relative to a scenario start.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: absolute deadlines instead of a timer. Phase 0 idle, 1 pressing,
  // 2 holding (first interval is H, later ones R), 3 releasing.
  int m_n, ph, dl;
  bit rep, m_s1, m_s2, m_bs, m_fire, m_sat;
  bit e_inc0, e_dec0, e_lim0, e_inc1, e_dec1, e_clr, e_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; ph = 0; dl = 0; rep = 0; m_s1 = 0; m_s2 = 0;
      e_inc0 = 0; e_dec0 = 0; e_lim0 = 0; e_inc1 = 0; e_dec1 = 0; e_clr = 0; e_busy = 0;
    end else begin
      m_n = m_n + 1;
      m_bs = m_s2; m_s2 = m_s1; m_s1 = button;
      m_fire = 0;
      case (ph)
        0: if (m_bs) begin ph = 1; dl = m_n + D; end
        1: if (!m_bs) ph = 0;
           else if (m_n == dl) begin m_fire = 1; ph = 2; rep = 0; dl = m_n + H; end
        2: if (!m_bs) begin ph = 3; dl = m_n + D; end
           else if (m_n == dl) begin m_fire = 1; rep = 1; dl = m_n + R; end
        default: if (m_bs) begin ph = 2; rep = 0; dl = m_n + H; end
                 else if (m_n == dl) ph = 0;
      endcase
      m_sat  = dir_up ? (cnt_val == 8'hFF) : (cnt_val == 8'h00);
      e_clr  = clr_req;
      e_inc0 = m_fire && !clr_req && dir_up && !m_sat;
      e_dec0 = m_fire && !clr_req && !dir_up && !m_sat;
      e_lim0 = m_fire && !clr_req && m_sat;
      e_inc1 = m_fire && !clr_req && dir_up;
      e_dec1 = m_fire && !clr_req && !dir_up;
      e_busy = (ph != 0);
    end
  end

  // Per-scenario pulse records (edge index relative to base).
  int base = 0;
  int q_inc0[$], q_dec0[$], q_lim0[$], q_clr0[$], q_inc1[$], q_lim1[$], q_bfall[$];
  int busy_cnt = 0;
  bit prev_busy = 0;

  always @(negedge clk) begin
    check("inc0",  o0_inc,  e_inc0);
    check("dec0",  o0_dec,  e_dec0);
    check("lim0",  o0_lim,  e_lim0);
    check("clr0",  o0_clr,  e_clr);
    check("busy0", o0_busy, e_busy);
    check("inc1",  o1_inc,  e_inc1);
    check("dec1",  o1_dec,  e_dec1);
    check("lim1",  o1_lim,  0);
    check("clr1",  o1_clr,  e_clr);
    check("busy1", o1_busy, e_busy);
    if (o0_inc) q_inc0.push_back(cyc - base);
    if (o0_dec) q_dec0.push_back(cyc - base);
    if (o0_lim) q_lim0.push_back(cyc - base);
    if (o0_clr) q_clr0.push_back(cyc - base);
    if (o1_inc) q_inc1.push_back(cyc - base);
    if (o1_lim) q_lim1.push_back(cyc - base);
    if (prev_busy && !o0_busy) q_bfall.push_back(cyc - base);
    if (o0_busy) busy_cnt++;
    prev_busy = o0_busy;
  end

  function automatic int first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  // Called on a negedge: the next posedge becomes relative edge 0.
  task automatic start_scn();
    q_inc0.delete(); q_dec0.delete(); q_lim0.delete(); q_clr0.delete();
    q_inc1.delete(); q_lim1.delete(); q_bfall.delete();
    busy_cnt = 0;
    base = cyc + 1;
  endtask

  task automatic press(input int high_cycles, input int tail_cycles);
    button = 1'b1;
    repeat (high_cycles) @(negedge clk);
    button = 1'b0;
    repeat (tail_cycles) @(negedge clk);
  endtask

  int exp_dec[6] = '{6, 16, 19, 22, 25, 28};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_inc", o0_inc, 0);
    check("rst_busy", o0_busy, 0);
    check("rst_clr", o0_clr, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press
    dir_up = 1'b1; cnt_val = 8'h10;
    start_scn();
    press(8, 14);
    check("clean_inc_n", q_inc0.size(), 1);
    check("clean_inc_edge", first(q_inc0), 6);
    check("clean_dec_n", q_dec0.size(), 0);
    check("clean_busy_fall", first(q_bfall), 14);

    // Glitch
    start_scn();
    press(3, 15);
    check("glitch_pulses", q_inc0.size() + q_dec0.size(), 0);
    check("glitch_busy_cycles", busy_cnt, 3);

    // Long hold, down
    dir_up = 1'b0; cnt_val = 8'h80;
    start_scn();
    press(29, 15);
    check("hold_dec_n", q_dec0.size(), 6);
    foreach (exp_dec[i]) check("hold_dec_edge", (i < q_dec0.size()) ? q_dec0[i] : -1, exp_dec[i]);

    // Saturation at 0xFF going up
    dir_up = 1'b1; cnt_val = 8'hFF;
    start_scn();
    press(8, 14);
    check("sat_inc0_n", q_inc0.size(), 0);
    check("sat_lim0_edge", first(q_lim0), 6);
    check("sat_inc1_edge", first(q_inc1), 6);
    check("sat_lim1_n", q_lim1.size(), 0);

    // Clear collides with the first step
    cnt_val = 8'h10;
    start_scn();
    button = 1'b1;
    repeat (6) @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (11) @(negedge clk);
    button = 1'b0;
    repeat (15) @(negedge clk);
    check("clr_edge", first(q_clr0), 6);
    check("clr_n", q_clr0.size(), 1);
    check("clr_first_inc", first(q_inc0), 16);

    // Async reset while auto-repeating
    start_scn();
    button = 1'b1;
    repeat (21) @(negedge clk);
    check("pre_rst_busy", o0_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", o0_busy, 0);
    check("arst_pulses", o0_inc + o0_dec + o0_lim + o0_clr, 0);
    @(negedge clk);
    start_scn();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_inc", first(q_inc0), 6);
    button = 1'b0;
    repeat (20) @(negedge clk);

    // Randomized traffic; every cycle is checked against the model.
    for (int seg = 0; seg < 250; seg++) begin
      int dwell;
      button = ~button;
      dwell = $urandom_range(1, 14);
      for (int c = 0; c < dwell; c++) begin
        if ($urandom_range(0, 7) == 0) dir_up = ~dir_up;
        clr_req = ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 3))
          0: cnt_val = 8'h00;
          1: cnt_val = 8'hFF;
          default: cnt_val = 8'($urandom);
        endcase
        if (seg == 120 && c == 0) begin
          #1 rst_n = 1'b0;
          #2 rst_n = 1'b1;
        end
        @(negedge clk);
      end
    end
    button = 1'b0; clr_req = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
